// File: rtl/control_unit.sv
// Multi-cycle microcontroller control unit: FETCH/DECODE/EXEC sequencer with
// opcode decode, registered zero/carry flags and a sticky HALT state.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       zero,
  input  logic       carry,
  output logic       s_inc,
  output logic       s_skip,
  output logic       s_inm,
  output logic       we,
  output logic [2:0] ALUOp,
  output logic       pc_we,
  output logic       ir_we,
  output logic       halted
);

  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_JZ   = 6'b100001;
  localparam logic [5:0] OP_JNZ  = 6'b100010;
  localparam logic [5:0] OP_JC   = 6'b100011;
  localparam logic [5:0] OP_JNC  = 6'b100100;
  localparam logic [5:0] OP_SKZ  = 6'b100101;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t state;
  state_t next_state;
  logic   zf;
  logic   cf;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= next_state;
  end

  // Flags capture the datapath result only when an ALU op retires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zf <= 1'b0;
      cf <= 1'b0;
    end else if (state == EXEC && Opcode[5:4] == 2'b00) begin
      zf <= zero;
      cf <= carry;
    end
  end

  // Next-state and output decode
  always_comb begin
    next_state = state;
    s_inc      = 1'b0;
    s_skip     = 1'b0;
    s_inm      = 1'b0;
    we         = 1'b0;
    ALUOp      = 3'b000;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    halted     = 1'b0;
    case (state)
      INIT:   next_state = FETCH;
      FETCH: begin
        ir_we      = 1'b1;
        next_state = DECODE;
      end
      DECODE: next_state = EXEC;
      EXEC: begin
        if (Opcode == OP_HALT) begin
          next_state = HALT;
        end else begin
          next_state = FETCH;
          pc_we      = 1'b1;
          s_inc      = 1'b1;
          case (Opcode[5:4])
            2'b00: begin
              we    = 1'b1;
              ALUOp = Opcode[2:0];
            end
            2'b01: begin
              we    = 1'b1;
              s_inm = 1'b1;
            end
            default: begin
              case (Opcode)
                OP_J:    s_inc  = 1'b0;
                OP_JZ:   s_inc  = ~zf;
                OP_JNZ:  s_inc  = zf;
                OP_JC:   s_inc  = ~cf;
                OP_JNC:  s_inc  = cf;
                OP_SKZ:  s_skip = zf;
                default: s_inc  = 1'b1;
              endcase
            end
          endcase
        end
      end
      HALT:    halted     = 1'b1;
      default: next_state = INIT;
    endcase
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL expose: clk  input  1  system clock, all state updates on rising edge.
REQ-002 The block SHALL expose: reset  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL expose: Opcode  input  6  current instruction opcode from the microc datapath.
REQ-004 The block SHALL expose: zero  input  1  ALU zero flag, combinational from the datapath.
REQ-005 The block SHALL expose: carry  input  1  ALU carry flag, combinational from the datapath.
REQ-006 The block SHALL expose: s_inc  output  1  PC source select (1 = PC+1, 0 = jump target).
REQ-007 The block SHALL expose: s_skip  output  1  skip select (1 = PC+2 when s_inc=1).
REQ-008 The block SHALL expose: s_inm  output  1  register-file write source (1 = immediate, 0 = ALU).
REQ-009 The block SHALL expose: we  output  1  register-file write enable.
REQ-010 The block SHALL expose: ALUOp  output  3  ALU operation select.
REQ-011 The block SHALL expose: pc_we  output  1  PC load strobe.
REQ-012 The block SHALL expose: ir_we  output  1  instruction-register load strobe.
REQ-013 The block SHALL expose: halted  output  1  high while in HALT.

Function
REQ-014 States SHALL be INIT, FETCH, DECODE, EXEC, HALT; transitions INIT->FETCH->DECODE->EXEC->FETCH, each taking one clock.
REQ-015 From EXEC with Opcode=6'b111111, the next state SHALL be HALT instead of FETCH; HALT SHALL persist until reset.
REQ-016 INIT and DECODE SHALL drive all outputs 0 except halted=0.
REQ-017 FETCH SHALL drive ir_we=1 and all other outputs 0.
REQ-018 EXEC SHALL drive pc_we=1 for every opcode except HALT (6'b111111), and ir_we=0.
REQ-019 In EXEC, Opcode=2'b00_xxxx (ALU op) SHALL give we=1, s_inm=0, ALUOp=Opcode[2:0], s_inc=1, s_skip=0.
REQ-020 In EXEC, Opcode=2'b01_xxxx (load immediate) SHALL give we=1, s_inm=1, ALUOp=3'b000, s_inc=1, s_skip=0.
REQ-021 In EXEC, Opcode=6'b100000 (J) SHALL give s_inc=0, we=0.
REQ-022 In EXEC, conditional jumps SHALL give we=0, with s_inc=0 if the condition holds and s_inc=1 otherwise: 6'b100001 JZ (zf=1), 6'b100010 JNZ (zf=0), 6'b100011 JC (cf=1), 6'b100100 JNC (cf=0).
REQ-023 In EXEC, Opcode=6'b100101 (SKZ) SHALL give s_inc=1, with s_skip=zf and we=0.
REQ-024 In EXEC, every other opcode except 6'b111111 SHALL be a NOP: s_inc=1, s_skip=0, we=0, pc_we=1.
REQ-025 Internal flag registers zf/cf SHALL load zero/carry on the EXEC->FETCH edge of ALU ops (REQ-019) only; all other instructions SHALL hold them.
REQ-026 Conditional jumps and SKZ SHALL use the registered zf/cf, never the live zero/carry inputs.
REQ-027 Outputs SHALL be decoded from state, Opcode and zf/cf only; Opcode SHALL be ignored outside EXEC.
REQ-028 HALT SHALL drive halted=1 with all other outputs 0.
REQ-029 Each instruction SHALL take exactly 3 clocks (FETCH, DECODE, EXEC); we and pc_we SHALL each be single-cycle pulses.

Reset
REQ-030 Asserting reset SHALL force state INIT and zf=cf=0 immediately, independent of clk; all outputs SHALL read 0 while reset is high.
REQ-031 Reset asserted mid-EXEC SHALL abort the instruction: we and pc_we SHALL fall within the same cycle, with no flag update.
REQ-032 After reset deasserts, the first rising edge SHALL enter FETCH.

Verification
REQ-033 Reset at t=0, deassert at 3 ns, 40 ns clock -> INIT, then ir_we=1 in the first FETCH cycle; all other outputs 0.
REQ-034 Opcode=6'b000011, zero=1 during EXEC -> we=1, ALUOp=3'b011, s_inc=1, pc_we=1 for one cycle; a subsequent JZ (6'b100001) -> s_inc=0.
REQ-035 Opcode=6'b010000 -> EXEC gives we=1, s_inm=1, pc_we=1; zf unchanged, so a following JNZ after an ALU op with zero=0 -> s_inc=0.
REQ-036 ALU op with carry=1, then SKZ with zf=0 -> s_skip=0; JC -> s_inc=0; JNC -> s_inc=1.
REQ-037 Opcode=6'b111111 -> after EXEC, halted=1 and pc_we=0 for 10+ cycles regardless of Opcode; reset returns the block to INIT with halted=0.
REQ-038 Reset pulse during EXEC of an ALU op -> we drops asynchronously, and zf/cf read 0 on the next JZ/JC.
